// File: rtl/rename_stage_pkg.sv
// Shared types and sizing for the 2-wide rename stage and its free list.
package rename_stage_pkg;
    localparam int FETCH_W   = 2;
    localparam int XLEN      = 32;
    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int PREG_W    = 6;
    localparam int AREG_W    = 5;
    localparam int XZR_IDX   = 31;
    localparam int FL_DEPTH  = PHYS_REGS - ARCH_REGS;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [AREG_W-1:0] areg_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [7:0]      opcode;
        logic            has_dest;
        areg_t           arch_rd;
        preg_t           prd;
        preg_t           prs1;
        preg_t           prs2;
        preg_t           old_prd;
        logic [XLEN-1:0] imm;
        logic            is_branch;
        logic            is_load;
        logic            is_store;
    } rename_bundle_t;

    // Stores, branches and writes to the zero register never take a new mapping.
    function automatic logic writes_reg(logic valid, logic is_store, logic is_branch, areg_t rd);
        return valid & ~is_store & ~is_branch & (rd != areg_t'(XZR_IDX));
    endfunction
endpackage

// File: rtl/rename_stage_free_list.sv
// Circular free list of physical registers: speculative head, committed head, tail.
module free_list
    import rename_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         pop_count,
    output preg_t              pop_data [FETCH_W],
    input  logic [FETCH_W-1:0] push_valid,
    input  preg_t              push_data [FETCH_W],
    input  logic               flush,
    output logic [PREG_W-1:0]  free_count
);
    localparam int IDX_W = $clog2(FL_DEPTH);
    typedef logic [IDX_W:0] ptr_t;

    preg_t            entries [FL_DEPTH];
    ptr_t             head, committed_head, tail;
    ptr_t             head_next, committed_head_next, tail_next;
    logic [1:0]       push_count;
    logic [IDX_W-1:0] head_idx1, push_idx1;

    assign push_count = 2'(push_valid[0]) + 2'(push_valid[1]);
    assign head_idx1  = head[IDX_W-1:0] + IDX_W'(1);
    assign push_idx1  = push_valid[0] ? tail[IDX_W-1:0] + IDX_W'(1) : tail[IDX_W-1:0];

    assign pop_data[0] = entries[head[IDX_W-1:0]];
    assign pop_data[1] = entries[head_idx1];

    // Commits retire the oldest speculative pops, so committed_head moves with the tail.
    assign committed_head_next = committed_head + ptr_t'(push_count);
    assign tail_next           = tail + ptr_t'(push_count);
    assign head_next           = flush ? committed_head_next : head + ptr_t'(pop_count);

    assign free_count = PREG_W'(tail - head);

    always_ff @(posedge clk) begin
        if (reset) begin
            head           <= '0;
            committed_head <= '0;
            tail           <= ptr_t'(FL_DEPTH);
            // NOTE: the storage is reset on purpose because the initial free pregs live in it.
            for (int i = 0; i < FL_DEPTH; i++) entries[i] <= preg_t'(ARCH_REGS + i);
        end else begin
            head           <= head_next;
            committed_head <= committed_head_next;
            tail           <= tail_next;
            if (push_valid[0]) entries[tail[IDX_W-1:0]] <= push_data[0];
            if (push_valid[1]) entries[push_idx1]       <= push_data[1];
        end
    end

    a_occupancy : assert property (@(posedge clk) disable iff (reset)
        (ptr_t'(tail_next - head_next)) <= ptr_t'(FL_DEPTH));
endmodule

// File: rtl/rename_stage.sv
// 2-wide register rename: speculative/committed RATs, intra-group bypass, registered output bundle.
module rename_stage
    import rename_stage_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [FETCH_W-1:0]  decode_valid,
    input  logic [XLEN-1:0]     decode_pc        [FETCH_W],
    input  logic [7:0]          decode_opcode    [FETCH_W],
    input  logic [4:0]          decode_arch_rd   [FETCH_W],
    input  logic [4:0]          decode_arch_rs1  [FETCH_W],
    input  logic [4:0]          decode_arch_rs2  [FETCH_W],
    input  logic [XLEN-1:0]     decode_imm       [FETCH_W],
    input  logic                decode_is_branch [FETCH_W],
    input  logic                decode_is_load   [FETCH_W],
    input  logic                decode_is_store  [FETCH_W],
    output logic                rename_ready,
    input  logic                dispatch_ready,
    output logic [FETCH_W-1:0]  rn_valid,
    output logic [XLEN-1:0]     rn_pc            [FETCH_W],
    output logic [XLEN-1:0]     rn_imm           [FETCH_W],
    output logic [7:0]          rn_opcode        [FETCH_W],
    output logic                rn_is_branch     [FETCH_W],
    output logic                rn_is_load       [FETCH_W],
    output logic                rn_is_store      [FETCH_W],
    output logic                rn_has_dest      [FETCH_W],
    output logic [4:0]          rn_arch_rd       [FETCH_W],
    output logic [PREG_W-1:0]   rn_prd           [FETCH_W],
    output logic [PREG_W-1:0]   rn_prs1          [FETCH_W],
    output logic [PREG_W-1:0]   rn_prs2          [FETCH_W],
    output logic [PREG_W-1:0]   rn_old_prd       [FETCH_W],
    input  logic [FETCH_W-1:0]  commit_valid,
    input  logic                commit_has_dest  [FETCH_W],
    input  logic [4:0]          commit_arch_rd   [FETCH_W],
    input  logic [PREG_W-1:0]   commit_prd       [FETCH_W],
    input  logic [PREG_W-1:0]   commit_old_prd   [FETCH_W],
    input  logic                flush
);
    preg_t               rat [ARCH_REGS];
    preg_t               crat [ARCH_REGS];
    preg_t               crat_next [ARCH_REGS];
    preg_t               pop_data [FETCH_W];
    preg_t               prd [FETCH_W];
    preg_t               prs1 [FETCH_W];
    preg_t               prs2 [FETCH_W];
    preg_t               old_prd [FETCH_W];
    rename_bundle_t      next_bundle [FETCH_W];
    rename_bundle_t      out_q [FETCH_W];
    logic [FETCH_W-1:0]  out_valid, has_dest, alloc, commit_push;
    logic [PREG_W-1:0]   free_count;
    logic [1:0]          pop_count;
    logic                accept;

    // Ready never looks at decode_valid, so decode may depend on it freely.
    assign rename_ready = ~reset & ~flush & (~(|out_valid) | dispatch_ready)
                        & (free_count >= PREG_W'(FETCH_W));
    assign accept    = rename_ready & (|decode_valid);
    assign alloc     = has_dest & {FETCH_W{accept}};
    assign pop_count = 2'(alloc[0]) + 2'(alloc[1]);

    always_comb begin
        for (int s = 0; s < FETCH_W; s++) begin
            has_dest[s]    = writes_reg(decode_valid[s], decode_is_store[s],
                                        decode_is_branch[s], decode_arch_rd[s]);
            commit_push[s] = commit_valid[s] & commit_has_dest[s];
        end
    end

    // Slot1 takes the second free entry only when slot0 also allocates.
    assign prd[0] = has_dest[0] ? pop_data[0] : '0;
    assign prd[1] = has_dest[1] ? (has_dest[0] ? pop_data[1] : pop_data[0]) : '0;

    assign prs1[0]    = rat[decode_arch_rs1[0]];
    assign prs2[0]    = rat[decode_arch_rs2[0]];
    assign old_prd[0] = rat[decode_arch_rd[0]];
    assign prs1[1]    = (has_dest[0] && decode_arch_rs1[1] == decode_arch_rd[0]) ? prd[0]
                                                                                 : rat[decode_arch_rs1[1]];
    assign prs2[1]    = (has_dest[0] && decode_arch_rs2[1] == decode_arch_rd[0]) ? prd[0]
                                                                                 : rat[decode_arch_rs2[1]];
    assign old_prd[1] = (has_dest[0] && decode_arch_rd[1] == decode_arch_rd[0]) ? prd[0]
                                                                                : rat[decode_arch_rd[1]];

    always_comb begin
        // NOTE: start from the registered copy so every entry is assigned on every path (no latch).
        crat_next = crat;
        for (int s = 0; s < FETCH_W; s++)
            if (commit_push[s]) crat_next[commit_arch_rd[s]] = commit_prd[s];
    end

    always_comb begin
        for (int s = 0; s < FETCH_W; s++) begin
            next_bundle[s] = '{pc: decode_pc[s], opcode: decode_opcode[s], has_dest: has_dest[s],
                               arch_rd: decode_arch_rd[s], prd: prd[s], prs1: prs1[s],
                               prs2: prs2[s], old_prd: old_prd[s], imm: decode_imm[s],
                               is_branch: decode_is_branch[s], is_load: decode_is_load[s],
                               is_store: decode_is_store[s]};
        end
    end

    free_list u_free_list (
        .clk        (clk),
        .reset      (reset),
        .pop_count  (pop_count),
        .pop_data   (pop_data),
        .push_valid (commit_push),
        .push_data  (commit_old_prd),
        .flush      (flush),
        .free_count (free_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat[i]  <= preg_t'(i);
                crat[i] <= preg_t'(i);
            end
        end else begin
            crat <= crat_next;
            if (flush) begin
                rat <= crat_next;
            end else begin
                // NOTE: non-blocking writes in slot order make slot1 win a same-rd collision.
                for (int s = 0; s < FETCH_W; s++)
                    if (alloc[s]) rat[decode_arch_rd[s]] <= prd[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= '0;
            for (int s = 0; s < FETCH_W; s++) out_q[s] <= '0;
        end else if (flush) begin
            out_valid <= '0;
        end else if (accept) begin
            out_valid <= decode_valid;
            out_q     <= next_bundle;
        end else if (dispatch_ready) begin
            out_valid <= '0;
        end
    end

    assign rn_valid = out_valid;
    always_comb begin
        for (int s = 0; s < FETCH_W; s++) begin
            rn_pc[s]        = out_q[s].pc;
            rn_imm[s]       = out_q[s].imm;
            rn_opcode[s]    = out_q[s].opcode;
            rn_is_branch[s] = out_q[s].is_branch;
            rn_is_load[s]   = out_q[s].is_load;
            rn_is_store[s]  = out_q[s].is_store;
            rn_has_dest[s]  = out_q[s].has_dest;
            rn_arch_rd[s]   = out_q[s].arch_rd;
            rn_prd[s]       = out_q[s].prd;
            rn_prs1[s]      = out_q[s].prs1;
            rn_prs2[s]      = out_q[s].prs2;
            rn_old_prd[s]   = out_q[s].old_prd;
        end
    end
endmodule
